pc_ctrl: RTL

Program-counter controller for the RV32I core. It holds the architectural PC and runs the fetch/execute sequence against instruction memory through a request/acknowledge handshake. It also presents the fetched instruction to the decode and execute units. When an instruction completes, it merges the `reg_pc_w_op`/`reg_pc_w_val` requests from the per-class execute units (environment, branch, jump, …) into the next PC.

---
 rtl/rv32i_pkg.sv | 18 +
 rtl/pc_w_arb.sv | 28 ++
 rtl/pc_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I core: PC controller state encoding, instruction
// length and the default reset vector.
package rv32i_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StExec  = 2'd2;
  localparam logic [1:0] StHalt  = 2'd3;

  localparam logic [31:0] ILEN             = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // RV32I without the C extension requires word-aligned instruction addresses.
  function automatic logic pc_aligned(input logic [31:0] pc);
    return pc[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/pc_w_arb.sv
// Lowest-index priority select over the per-unit PC write requests. Also reports
// whether any request is present and whether more than one unit asked at once.
module pc_w_arb
  import rv32i_pkg::*;
#(
  parameter int unsigned N_SRC = 4
) (
  input  logic [N_SRC-1:0]    req,
  input  logic [N_SRC*32-1:0] val,
  output logic                sel_valid,
  output logic [31:0]         sel_val,
  output logic                multi
);

  always_comb begin
    sel_valid = |req;
    sel_val   = '0;
    // Scan downwards so the lowest set index is the last, and winning, assignment.
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel_val = val[32*i +: 32];
      end
    end
    // Clearing the lowest set bit leaves something only if two or more were set.
    multi = (req & (req - 1'b1)) != '0;
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller: holds the PC, runs fetch/execute against instruction
// memory, and merges execute-unit PC writes into the next PC on completion.
module pc_ctrl
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned N_SRC    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SRC-1:0]    reg_pc_w_op,
  input  logic [N_SRC*32-1:0] reg_pc_w_val,
  input  logic                exec_done,
  input  logic                fetch_ack,
  input  logic [31:0]         fetch_data,
  output logic [31:0]         reg_pc_val,
  output logic                fetch_req,
  output logic [31:0]         fetch_addr,
  output logic                ins_valid,
  output logic [31:0]         ins_data,
  output logic                fault_misalign,
  output logic                multi_w
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fetch_req_q, fetch_req_d;
  logic        ins_valid_q, ins_valid_d;
  logic [31:0] ins_data_q, ins_data_d;
  logic        fault_q, fault_d;
  logic        multi_q, multi_d;

  logic        arb_valid;
  logic [31:0] arb_val;
  logic        arb_multi;
  logic [31:0] next_pc;

  pc_w_arb #(
    .N_SRC(N_SRC)
  ) u_pc_w_arb (
    .req      (reg_pc_w_op),
    .val      (reg_pc_w_val),
    .sel_valid(arb_valid),
    .sel_val  (arb_val),
    .multi    (arb_multi)
  );

  // Addition wraps modulo 2^32, so the last word of the address space falls through to 0.
  assign next_pc = arb_valid ? arb_val : pc_q + ILEN;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_req_d = fetch_req_q;
    ins_valid_d = ins_valid_q;
    ins_data_d  = ins_data_q;
    fault_d     = fault_q;
    multi_d     = multi_q;

    unique case (state_q)
      StIdle: begin
        state_d     = StFetch;
        fetch_req_d = 1'b1;
      end
      StFetch: begin
        if (fetch_ack) begin
          ins_data_d  = fetch_data;
          ins_valid_d = 1'b1;
          fetch_req_d = 1'b0;
          state_d     = StExec;
        end
      end
      StExec: begin
        if (exec_done) begin
          ins_valid_d = 1'b0;
          if (arb_multi) begin
            multi_d = 1'b1;
          end
          if (!pc_aligned(next_pc)) begin
            fault_d = 1'b1;
            state_d = StHalt;
          end else begin
            pc_d        = next_pc;
            fetch_req_d = 1'b1;
            state_d     = StFetch;
          end
        end
      end
      StHalt: begin
        fetch_req_d = 1'b0;
        ins_valid_d = 1'b0;
      end
      default: begin
        state_d     = StIdle;
        fetch_req_d = 1'b0;
        ins_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      fetch_req_q <= 1'b0;
      ins_valid_q <= 1'b0;
      ins_data_q  <= '0;
      fault_q     <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_req_q <= fetch_req_d;
      ins_valid_q <= ins_valid_d;
      ins_data_q  <= ins_data_d;
      fault_q     <= fault_d;
      multi_q     <= multi_d;
    end
  end

  assign reg_pc_val     = pc_q;
  assign fetch_addr     = pc_q;
  assign fetch_req      = fetch_req_q;
  assign ins_valid      = ins_valid_q;
  assign ins_data       = ins_data_q;
  assign fault_misalign = fault_q;
  assign multi_w        = multi_q;

endmodule
